// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline: STAGES valid/ready stages with bubble collapsing, flush and occupancy.
// Optional stall counter port stall_cnt is built only when PIPE_STALL_CNT_EN is defined.
module pipe_reg_chain #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 4,
  localparam int CW        = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CW-1:0]         occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // Handshake: a word moves across a boundary on the edge where valid & ready are both 1.
  logic [STAGES-1:0]     r_v;
  logic [DATA_WIDTH-1:0] r_d [STAGES];

  logic [STAGES-1:0]     w_rdy;
  logic [STAGES-1:0]     w_vin;
  logic [DATA_WIDTH-1:0] w_din [STAGES];
  logic [CW-1:0]         w_occ;

  // Stage i can load when it is empty or anything downstream of it can move.
  always_comb begin
    logic acc;
    acc   = out_ready;
    w_rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc      = acc | !r_v[i];
      w_rdy[i] = acc;
    end
  end

  always_comb begin
    w_vin    = '0;
    w_vin[0] = in_valid;
    w_din[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      w_vin[i] = r_v[i-1];
      w_din[i] = r_d[i-1];
    end
  end

  always_comb begin
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt = cnt + CW'(r_v[i]);
    end
    w_occ = cnt;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_d[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_vin[i];
          // Payload only moves with a valid word so a drained stage keeps its last data.
          if (w_vin[i]) begin
            r_d[i] <= w_din[i];
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] & !flush;
  assign out_valid = r_v[STAGES-1] & !flush;
  assign out_data  = r_d[STAGES-1];
  assign occupancy = w_occ;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_stall <= '0;
    end else if (flush) begin
      r_stall <= '0;
    end else if (r_v[STAGES-1] && !out_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (DATA_WIDTH=8, STAGES=4): vector table plus hand-written corner sequences.
// Stall counter checks are included when PIPE_STALL_CNT_EN is defined.
module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       rst_;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;
  vec_t tv[$];

  pipe_reg_chain #(.DATA_WIDTH(8), .STAGES(4)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: record accepted words, compare each delivered word against the oldest one.
  task automatic sb_sample();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_out", 16'(out_data), 16'hFFFF);
      else chk("sb_order", 16'(out_data), 16'(exp_q.pop_front()));
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
  endtask

  task automatic drive(input logic f, input logic iv, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    sb_sample();
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                     input logic [2:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    tv.push_back(v);
  endtask

  initial begin
    bit seen;
    rst_ = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Streaming: one word per cycle, first word visible after the 4th edge.
    add(1, 8'h01, 1, 1, 0, 8'h00, 0);
    add(1, 8'h02, 1, 1, 0, 8'h00, 1);
    add(1, 8'h03, 1, 1, 0, 8'h00, 2);
    add(1, 8'h04, 1, 1, 0, 8'h00, 3);
    add(1, 8'h05, 1, 1, 1, 8'h01, 4);
    add(1, 8'h06, 1, 1, 1, 8'h02, 4);
    add(1, 8'h07, 1, 1, 1, 8'h03, 4);
    add(1, 8'h08, 1, 1, 1, 8'h04, 4);
    add(0, 8'h00, 1, 1, 1, 8'h05, 4);
    add(0, 8'h00, 1, 1, 1, 8'h06, 3);
    add(0, 8'h00, 1, 1, 1, 8'h07, 2);
    add(0, 8'h00, 1, 1, 1, 8'h08, 1);
    add(0, 8'h00, 1, 1, 0, 8'h08, 0);
    // Backpressure: four words fill the pipe, the fifth waits until out_ready returns.
    add(1, 8'hA0, 0, 1, 0, 8'h08, 0);
    add(1, 8'hA1, 0, 1, 0, 8'h08, 1);
    add(1, 8'hA2, 0, 1, 0, 8'h08, 2);
    add(1, 8'hA3, 0, 1, 0, 8'h08, 3);
    add(1, 8'hA4, 0, 0, 1, 8'hA0, 4);
    add(1, 8'hA4, 0, 0, 1, 8'hA0, 4);
    add(1, 8'hA4, 1, 1, 1, 8'hA0, 4);
    add(0, 8'h00, 1, 1, 1, 8'hA1, 4);
    add(0, 8'h00, 1, 1, 1, 8'hA2, 3);
    add(0, 8'h00, 1, 1, 1, 8'hA3, 2);
    add(0, 8'h00, 1, 1, 1, 8'hA4, 1);
    add(0, 8'h00, 1, 1, 0, 8'hA4, 0);

    // Reset state.
    #3;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data",  16'(out_data),  16'h0);
    chk("rst_occupancy", 16'(occupancy), 16'h0);
    chk("rst_in_ready",  16'(in_ready),  16'h1);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 16'h0);
`endif
    @(negedge clk);
    rst_ = 1'b1;

    for (int k = 0; k < tv.size(); k++) begin
      drive(1'b0, tv[k].iv, tv[k].d, tv[k].ordy);
      chk($sformatf("vec%0d_in_ready", k),  16'(in_ready),  16'(tv[k].e_ir));
      chk($sformatf("vec%0d_out_valid", k), 16'(out_valid), 16'(tv[k].e_ov));
      chk($sformatf("vec%0d_out_data", k),  16'(out_data),  16'(tv[k].e_od));
      chk($sformatf("vec%0d_occupancy", k), 16'(occupancy), 16'(tv[k].e_occ));
    end

    // Bubble collapse: the gap between 0x11 and 0x22 disappears behind the stalled head.
    drive(0, 1, 8'h11, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h22, 0);
    for (int k = 0; k < 4; k++) drive(0, 0, 8'h00, 0);
    chk("bub_occupancy", 16'(occupancy), 16'h2);
    chk("bub_out_valid", 16'(out_valid), 16'h1);
    chk("bub_head",      16'(out_data),  16'h11);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    chk("bub_next",      16'(out_data),  16'h22);
    chk("bub_occ_after", 16'(occupancy), 16'h1);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    chk("bub_drained",   16'(occupancy), 16'h0);

    // Asynchronous reset with three words in flight.
    drive(0, 1, 8'h31, 0);
    drive(0, 1, 8'h32, 0);
    drive(0, 1, 8'h33, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    chk("prerst_occupancy", 16'(occupancy), 16'h3);
    chk("prerst_out_data",  16'(out_data),  16'h31);
    #2;
    rst_ = 1'b0;
    #1;
    chk("midrst_out_valid", 16'(out_valid), 16'h0);
    chk("midrst_out_data",  16'(out_data),  16'h0);
    chk("midrst_occupancy", 16'(occupancy), 16'h0);
    chk("midrst_in_ready",  16'(in_ready),  16'h1);
    exp_q.delete();
    @(negedge clk);
    rst_ = 1'b1;

    // Flush beats a pending input and output transfer in the same cycle.
    drive(0, 1, 8'h51, 0);
    drive(0, 1, 8'h52, 0);
    drive(0, 1, 8'h53, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    chk("preflush_occupancy", 16'(occupancy), 16'h3);
    chk("preflush_out_valid", 16'(out_valid), 16'h1);
    drive(1, 1, 8'h5F, 1);
    chk("flush_in_ready",  16'(in_ready),  16'h0);
    chk("flush_out_valid", 16'(out_valid), 16'h0);
    drive(0, 0, 8'h00, 0);
    chk("postflush_occupancy", 16'(occupancy), 16'h0);
    chk("postflush_out_valid", 16'(out_valid), 16'h0);
    chk("postflush_data_kept", 16'(out_data),  16'h51);
    exp_q.delete();

`ifdef PIPE_STALL_CNT_EN
    // Stall counter: ten stalled edges, then cleared by flush.
    drive(0, 1, 8'h66, 0);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      drive(0, 0, 8'h00, 0);
      seen = out_valid;
    end
    chk("stall_fill_done", 16'(seen), 16'h1);
    chk("stall_start", stall_cnt, 16'd0);
    for (int k = 0; k < 10; k++) drive(0, 0, 8'h00, 0);
    chk("stall_ten", stall_cnt, 16'd10);
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    chk("stall_flushed", stall_cnt, 16'd0);
    exp_q.delete();
`else
    seen = 1'b0;
`endif

    chk("sb_leftover", 16'(exp_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
